// File: rtl/stopwatch_digit_source.sv
// -----------------------------------------------------------------------------
// stopwatch_digit_source
//
// Four-digit BCD stopwatch. It feeds the val3..val0 nibbles of a quad
// seven-segment display driver. Two raw push-buttons (start/stop and clear)
// are synchronised and debounced. The system clock is divided down to a
// count tick, and each tick advances a cascaded BCD counter.
//
// Parameters
//   TICK_DIV   : clock cycles per count tick (>= 2)
//   DEB_CYCLES : consecutive stable cycles before a button level is accepted (>= 2)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   btn_ss   in   raw start/stop button (asynchronous, active-high)
//   btn_clr  in   raw clear button (asynchronous, active-high)
//   val3     out  thousands digit (BCD), registered
//   val2     out  hundreds digit (BCD), registered
//   val1     out  tens digit (BCD), registered
//   val0     out  units digit (BCD), registered
//   running  out  high while counting, registered
//   ovf      out  sticky 9999 -> 0000 wrap flag, registered
//
// Handshake note: there is no valid/ready interface. Each conditioned button
// produces a single-cycle press pulse. The run-control logic consumes that
// pulse on the clock edge that ends the pulse cycle. No back-pressure exists.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// stopwatch_btn_cond
//
// Conditions one button input: a two-flop synchroniser, then a counter-based
// debouncer, then rising-edge detection.
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   btn_raw  in   raw asynchronous button level
//   press_o  out  one-cycle registered pulse on each accepted press
// -----------------------------------------------------------------------------
module stopwatch_btn_cond #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_o
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    cnt_d      = '0;
    deb_d      = deb_q;
    // The counter only runs while the synchronised level disagrees with the
    // accepted level. Any agreement restarts the count, which is why a glitch
    // shorter than DEB_CYCLES is discarded.
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DEB_ONE;
      end
    end
    deb_prev_d = deb_q;
    // Rising edge of the accepted level only. A release and a long hold give
    // no further pulse.
    press_d    = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// -----------------------------------------------------------------------------
// Top level
// -----------------------------------------------------------------------------
module stopwatch_digit_source #(
  parameter int TICK_DIV   = 1000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] val3,
  output logic [3:0] val2,
  output logic [3:0] val1,
  output logic [3:0] val0,
  output logic       running,
  output logic       ovf
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic ss_press;
  logic clr_press;

  stopwatch_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ss_cond (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_ss),
    .press_o (ss_press)
  );

  stopwatch_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr_cond (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clr),
    .press_o (clr_press)
  );

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic             running_q, running_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             carry;

  always_comb begin
    presc_d   = presc_q;
    dig_d     = dig_q;
    running_d = running_q;
    ovf_d     = ovf_q;
    carry     = 1'b0;

    // The tick uses the current (pre-toggle) running value. A start/stop
    // pulse that lands on the tick cycle therefore still applies that tick.
    tick = running_q && (presc_q == PRE_LAST);

    // The prescaler holds while stopped, so a restart resumes mid-period.
    if (running_q) begin
      if (tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end

    // BCD ripple: the carry starts as the tick and propagates through each
    // digit that is at 9. The >= guard keeps every digit inside 0..9.
    carry = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] >= 4'd9) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    // A carry out of the thousands digit means 9999 -> 0000.
    ovf_d = ovf_q | carry;

    if (ss_press) begin
      running_d = ~running_q;
    end

    // Clear overrides the tick in the same cycle. It does not touch running.
    if (clr_press) begin
      dig_d   = '0;
      presc_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      dig_q     <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      dig_q     <= dig_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  assign val0    = dig_q[0];
  assign val1    = dig_q[1];
  assign val2    = dig_q[2];
  assign val3    = dig_q[3];
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_digit_source.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_digit_source
//
// Directed bench for stopwatch_digit_source with TICK_DIV=4 and DEB_CYCLES=3.
// Inputs change 1 time unit after a rising edge. A button raised after edge X
// is first sampled at X+1, so the resulting action is visible after edge X+7.
// Edge labels in the comments below count rising edges from a named point.
// -----------------------------------------------------------------------------
module tb_stopwatch_digit_source;

  logic       clk;
  logic       rst_n;
  logic       btn_ss;
  logic       btn_clr;
  logic [3:0] val3, val2, val1, val0;
  logic       running;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  logic [15:0] digits;
  assign digits = {val3, val2, val1, val0};

  stopwatch_digit_source #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .val3    (val3),
    .val2    (val2),
    .val1    (val1),
    .val0    (val0),
    .running (running),
    .ovf     (ovf)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;

    // Reset held for 5 cycles while the buttons toggle.
    for (int i = 0; i < 5; i++) begin
      btn_ss  = (i % 2) == 0;
      btn_clr = (i % 2) != 0;
      step(1);
    end
    check("rst_digits", digits, 16'h0000);
    check_bit("rst_running", running, 1'b0);
    check_bit("rst_ovf", ovf, 1'b0);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    rst_n   = 1'b1;
    step(10);
    check("post_rst_digits", digits, 16'h0000);
    check_bit("post_rst_running", running, 1'b0);

    // A 2-cycle glitch is rejected.
    btn_ss = 1'b1;
    step(2);
    btn_ss = 1'b0;
    step(10);
    check_bit("glitch_no_toggle", running, 1'b0);

    // 10-cycle hold: running rises exactly 6 edges after the first sampled edge.
    btn_ss = 1'b1;
    step(6);
    check_bit("deb_not_yet", running, 1'b0);
    step(1);                                   // R: running up, prescaler 0
    check_bit("deb_start", running, 1'b1);
    check("start_digits", digits, 16'h0000);
    step(3);                                   // R+3: tick cycle
    check("first_tick_pending", digits, 16'h0000);
    btn_ss = 1'b0;
    step(1);                                   // R+4
    check("first_tick", digits, 16'h0001);
    step(20);                                  // R+24
    check_bit("single_toggle", running, 1'b1);

    // Second hold stops the count at edge R+31 (digits 0007, prescaler 3).
    btn_ss = 1'b1;
    step(6);
    check_bit("stop_not_yet", running, 1'b1);
    step(1);
    check_bit("stop", running, 1'b0);
    check("stop_digits", digits, 16'h0007);
    step(3);
    btn_ss = 1'b0;
    step(10);
    check("stopped_frozen", digits, 16'h0007);

    // Clear while stopped.
    btn_clr = 1'b1;
    step(7);
    btn_clr = 1'b0;
    check("clr_stopped_digits", digits, 16'h0000);
    check_bit("clr_stopped_running", running, 1'b0);

    // Start from a cleared prescaler: after edge R+4k the digits read k.
    btn_ss = 1'b1;
    step(7);                                   // R
    btn_ss = 1'b0;
    check_bit("count_start", running, 1'b1);
    step(159);
    check("cnt_0039", digits, 16'h0039);
    step(1);
    check("cnt_0040", digits, 16'h0040);
    step(236);
    check("cnt_0099", digits, 16'h0099);
    step(4);
    check("cnt_0100", digits, 16'h0100);
    step(3596);
    check("cnt_0999", digits, 16'h0999);
    step(4);
    check("cnt_1000", digits, 16'h1000);
    step(35996);
    check("cnt_9999", digits, 16'h9999);
    check_bit("ovf_before_wrap", ovf, 1'b0);
    step(4);
    check("wrap_digits", digits, 16'h0000);
    check_bit("wrap_ovf", ovf, 1'b1);
    step(8);                                   // Q
    check("after_wrap", digits, 16'h0002);
    check_bit("ovf_sticky", ovf, 1'b1);

    // Clear while running takes effect at Q+7 = C.
    btn_clr = 1'b1;
    step(6);
    check("pre_clr_digits", digits, 16'h0003);
    check_bit("pre_clr_ovf", ovf, 1'b1);
    step(1);                                   // C
    btn_clr = 1'b0;
    check("clr_run_digits", digits, 16'h0000);
    check_bit("clr_run_ovf", ovf, 1'b0);
    check_bit("clr_run_running", running, 1'b1);
    step(3);
    check("clr_tick_pending", digits, 16'h0000);
    step(1);                                   // C+4
    check("clr_first_tick", digits, 16'h0001);

    // Stop at C+14 with prescaler 2.
    step(3);
    btn_ss = 1'b1;
    step(7);                                   // S
    btn_ss = 1'b0;
    check_bit("mid_stop_running", running, 1'b0);
    check("mid_stop_digits", digits, 16'h0003);
    step(20);
    check("mid_stop_frozen", digits, 16'h0003);

    // Restart: the prescaler resumes at 2, so a tick comes after 1 cycle.
    btn_ss = 1'b1;
    step(7);                                   // R2
    btn_ss = 1'b0;
    check_bit("resume_running", running, 1'b1);
    check("resume_digits", digits, 16'h0003);
    step(1);
    check("resume_tick_pending", digits, 16'h0003);
    step(1);                                   // R2+2
    check("resume_tick", digits, 16'h0004);

    // Clear lands on the tick edge R2+10. Clear wins.
    step(1);
    btn_clr = 1'b1;
    step(6);
    check("pre_coll_clr", digits, 16'h0005);
    step(1);                                   // Cc
    btn_clr = 1'b0;
    check("coll_clr_digits", digits, 16'h0000);
    check_bit("coll_clr_running", running, 1'b1);
    step(3);
    check("coll_clr_pending", digits, 16'h0000);
    step(1);
    check("coll_clr_next_tick", digits, 16'h0001);

    // Start/stop lands on the tick edge Cc+12.
    step(1);
    btn_ss = 1'b1;
    step(6);
    check("pre_coll_ss", digits, 16'h0002);
    step(1);                                   // T
    btn_ss = 1'b0;
    check("coll_ss_digits", digits, 16'h0003);
    check_bit("coll_ss_running", running, 1'b0);
    step(12);
    check("coll_ss_frozen", digits, 16'h0003);

    // Reset mid-count.
    btn_ss = 1'b1;
    step(7);                                   // R3
    btn_ss = 1'b0;
    check_bit("restart_running", running, 1'b1);
    step(5);
    check("pre_rst_digits", digits, 16'h0004);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_digits", digits, 16'h0000);
    check_bit("mid_rst_running", running, 1'b0);
    check_bit("mid_rst_ovf", ovf, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("after_rst_digits", digits, 16'h0000);
    check_bit("after_rst_running", running, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
